mem_issue_queue: RTL

MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

---
 rtl/mem_issue_queue_if.sv | 32 +++
 rtl/mem_issue_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_issue_queue_if.sv
// Dispatch/issue bus of the memory issue queue: dispatch packet, wakeup, branch
// kill/clear broadcasts, downstream stall and the registered issue packet.
interface mem_issue_queue_if #(
    parameter int WIDTH_REG = 7,
    parameter int WIDTH_BRM = 6,
    parameter int WIDTH_D   = 3*WIDTH_REG+WIDTH_BRM+7+10+64+2,
    parameter int WIDTH_I   = 3*WIDTH_REG+WIDTH_BRM+7+10+64+1
);
    logic [WIDTH_D-1:0]   i_instr;
    logic                 i_wr;
    logic                 o_full;
    logic                 i_wake_en;
    logic [WIDTH_REG-1:0] i_wake_tag;
    logic                 i_brkill_en;
    logic [WIDTH_BRM-1:0] i_brkill_mask;
    logic                 i_brclr_en;
    logic [WIDTH_BRM-1:0] i_brclr_mask;
    logic                 i_stall;
    logic [WIDTH_I-1:0]   o_instr;

    modport master (
        output i_instr, i_wr, i_wake_en, i_wake_tag, i_brkill_en, i_brkill_mask,
               i_brclr_en, i_brclr_mask, i_stall,
        input  o_full, o_instr
    );

    modport slave (
        input  i_instr, i_wr, i_wake_en, i_wake_tag, i_brkill_en, i_brkill_mask,
               i_brclr_en, i_brclr_mask, i_stall,
        output o_full, o_instr
    );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: circular buffer with operand wakeup, branch kill/clear
// and a registered issue stage. MEM_ISSUE_QUEUE_FLUSH_EN adds a synchronous i_flush.
module mem_issue_queue #(
    parameter int WIDTH_REG = 7,
    parameter int WIDTH_BRM = 6,
    parameter int DEPTH_LOG = 3,
    parameter int WIDTH_D   = 3*WIDTH_REG+WIDTH_BRM+7+10+64+2,
    parameter int WIDTH_I   = 3*WIDTH_REG+WIDTH_BRM+7+10+64+1
) (
    input logic              i_clk,
    input logic              i_rst_n,
`ifdef MEM_ISSUE_QUEUE_FLUSH_EN
    input logic              i_flush,
`endif
    mem_issue_queue_if.slave bus
);
    localparam int DEPTH   = 1 << DEPTH_LOG;
    localparam int WIDTH_P = WIDTH_I - 1;             // issue packet minus valid
    localparam int BRM_LSB = 3*WIDTH_REG + 64 + 7;
    localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0]     rs2_rdy_q, rs2_rdy_d;
    logic [WIDTH_P-1:0]   payload_q [DEPTH];
    logic [DEPTH_LOG:0]   head_q, head_d, tail_q, tail_d;
    logic [WIDTH_I-1:0]   out_q, out_d;

    logic                 clear_all;
    logic [DEPTH_LOG-1:0] head_idx, tail_idx;
    logic [WIDTH_P-1:0]   in_payload, head_payload;
    logic                 empty, enq, issue, pop;
    logic                 in_rs1_rdy, in_rs2_rdy;

`ifdef MEM_ISSUE_QUEUE_FLUSH_EN
    assign clear_all = !i_rst_n || i_flush;
`else
    assign clear_all = !i_rst_n;
`endif

    function automatic logic [WIDTH_P-1:0] apply_clr(input logic [WIDTH_P-1:0] p,
                                                     input logic en,
                                                     input logic [WIDTH_BRM-1:0] m);
        logic [WIDTH_P-1:0] cm;
        cm = '0;
        if (en) cm[BRM_LSB +: WIDTH_BRM] = m;
        return p & ~cm;
    endfunction

    function automatic logic kill_hit(input logic [WIDTH_P-1:0] p,
                                      input logic en,
                                      input logic [WIDTH_BRM-1:0] m);
        return en && ((p[BRM_LSB +: WIDTH_BRM] & m) != '0);
    endfunction

    assign head_idx     = head_q[DEPTH_LOG-1:0];
    assign tail_idx     = tail_q[DEPTH_LOG-1:0];
    assign empty        = (head_q == tail_q);
    assign bus.o_full   = (head_idx == tail_idx) && (head_q[DEPTH_LOG] != tail_q[DEPTH_LOG]);
    assign bus.o_instr  = out_q;
    assign in_payload   = bus.i_instr[WIDTH_D-1:2];
    assign head_payload = payload_q[head_idx];
    assign enq          = bus.i_wr && !bus.o_full && !clear_all;

    // Ready bits for the incoming packet include a same-cycle wakeup bypass.
    assign in_rs1_rdy = bus.i_instr[0] ||
        (bus.i_wake_en && in_payload[0 +: WIDTH_REG] == bus.i_wake_tag);
    assign in_rs2_rdy = bus.i_instr[1] ||
        (bus.i_wake_en && in_payload[WIDTH_REG +: WIDTH_REG] == bus.i_wake_tag);

    assign issue = !empty && valid_q[head_idx] && rs1_rdy_q[head_idx] && rs2_rdy_q[head_idx] &&
                   !bus.i_stall && !kill_hit(head_payload, bus.i_brkill_en, bus.i_brkill_mask);
    assign pop   = issue || (!empty && !valid_q[head_idx]);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        valid_d   = valid_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        head_d    = head_q;
        tail_d    = tail_q;
        out_d     = out_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && bus.i_wake_en) begin
                if (payload_q[i][0 +: WIDTH_REG] == bus.i_wake_tag)         rs1_rdy_d[i] = 1'b1;
                if (payload_q[i][WIDTH_REG +: WIDTH_REG] == bus.i_wake_tag) rs2_rdy_d[i] = 1'b1;
            end
            if (kill_hit(payload_q[i], bus.i_brkill_en, bus.i_brkill_mask)) valid_d[i] = 1'b0;
        end

        if (pop) begin
            valid_d[head_idx]   = 1'b0;
            rs1_rdy_d[head_idx] = 1'b0;
            rs2_rdy_d[head_idx] = 1'b0;
            head_d              = head_q + PTR_ONE;
        end

        if (enq) begin
            valid_d[tail_idx]   = !kill_hit(in_payload, bus.i_brkill_en, bus.i_brkill_mask);
            rs1_rdy_d[tail_idx] = in_rs1_rdy;
            rs2_rdy_d[tail_idx] = in_rs2_rdy;
            tail_d              = tail_q + PTR_ONE;
        end

        // Stall holds the issue register; kill and clear still reach it.
        if (!bus.i_stall) out_d = issue ? {1'b1, head_payload} : {1'b0, out_q[WIDTH_P-1:0]};
        if (kill_hit(out_d[WIDTH_P-1:0], bus.i_brkill_en, bus.i_brkill_mask)) out_d[WIDTH_I-1] = 1'b0;
        out_d[WIDTH_P-1:0] = apply_clr(out_d[WIDTH_P-1:0], bus.i_brclr_en, bus.i_brclr_mask);
    end

    always_ff @(posedge i_clk) begin
        if (clear_all) begin
            head_q    <= '0;
            tail_q    <= '0;
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            out_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            head_q    <= head_d;
            tail_q    <= tail_d;
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            out_q     <= out_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; valid bits gate every use of it.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && tail_idx == DEPTH_LOG'(i))
                payload_q[i] <= apply_clr(in_payload, bus.i_brclr_en, bus.i_brclr_mask);
            else
                payload_q[i] <= apply_clr(payload_q[i], bus.i_brclr_en, bus.i_brclr_mask);
        end
    end
endmodule
